stress_trend_detector: RTL
==========================

# stress_trend_detector

Parametrised successor to the single-channel heart-rate stability checker in the stress input path. It watches a sampled physiological value, such as heart rate, on the slow sample clock. It declares a reading stable when DEPTH consecutive valid samples stay within TOL of the first sample of the run. Each stable reading is compared against the previous stable reading and reported as a rise, a fall or no change; the fall indication is what the downstream rocking controller uses. A programmable hold-off follows every event and replaces the old ad-hoc delay chain.

## Interface
- WIDTH, 6: sample width in bits (unsigned).
- DEPTH, 4: consecutive in-tolerance samples required for a stable event; legal range 2..15.
- TOL, 0: maximum allowed |sample − run_ref| for a sample to count as matching; TOL < 2^WIDTH.
- HOLDOFF, 4: clock cycles after an event during which samples are ignored; legal range 0..255.
- slow  in  1  the single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  sample is presented this cycle.
- sample  in  WIDTH  sample value.
- stable_pulse  out  1  one-cycle pulse per stable event.
- stable_value  out  WIDTH  run_ref of the last event; held until the next event.
- first  out  1  last event had no previous baseline; held.
- rising  out  1  last event's value > baseline; held.
- falling  out  1  last event's value < baseline; held.
- delta  out  WIDTH+1  signed two's-complement (value − baseline) of the last event; held.
- busy  out  1  high while in HOLDOFF.

## Operation
- Reset: all outputs are 0. Internal run_ref = 0, run_len = 0, baseline = 0, baseline_valid = 0, FSM enters FILL.
- FILL state. On an edge with sample_valid = 1:
  - If run_len = 0, or |sample − run_ref| > TOL: run_ref ← sample, run_len ← 1.
  - Otherwise run_len ← run_len + 1.
- Cycles with sample_valid = 0 neither break nor advance the run.
- Event: the accepted sample makes run_len reach DEPTH. On that edge:
  - stable_pulse ← 1, stable_value ← run_ref.
  - If baseline_valid = 0: first ← 1, rising ← 0, falling ← 0, delta ← 0.
  - Otherwise first ← 0, rising ← (run_ref > baseline), falling ← (run_ref < baseline), delta ← run_ref − baseline, computed in WIDTH+1 bits.
  - baseline ← run_ref, baseline_valid ← 1, run_len ← 0.
  - FSM → HOLDOFF, or stays in FILL if HOLDOFF = 0.
- HOLDOFF state: a counter loads HOLDOFF−1 at the event and decrements each edge. Samples are ignored. The FSM returns to FILL on the edge where the counter reads 0. busy = (state == HOLDOFF).
- The mismatch test uses the absolute difference in WIDTH bits with no wrap: 63 vs 0 is distance 63.
- Equal successive stable values give rising = falling = 0 and delta = 0, and still pulse.
- A run never fires twice. After an event it must refill DEPTH fresh samples, with run_ref taken from the first accepted sample.

## Timing
- The DEPTH-th matching sample is accepted at edge N. stable_pulse and all updated held outputs are visible from just after edge N until edge N+1. stable_pulse clears at N+1 unless a new event occurs.
- With HOLDOFF = H > 0, samples at edges N+1..N+H are ignored. The first sample that can be accepted is at edge N+H+1, so the earliest next pulse follows edge N+H+DEPTH.
- With HOLDOFF = 0, a sample at edge N+1 is accepted. The earliest next pulse follows edge N+DEPTH.
- reset has priority over everything on the same edge. It aborts a partial run or a hold-off and clears baseline_valid, so the next event reports first = 1.

## Test plan
Defaults unless stated: WIDTH=6, DEPTH=4, TOL=0, HOLDOFF=4.
- Reset, then 20,20,20,20 valid on consecutive edges → single pulse after the 4th edge; stable_value=20, first=1, rising=falling=0, delta=0; busy high for the next 4 cycles.
- After hold-off, 25 ×4 → pulse, stable_value=25, rising=1, first=0, delta=+5 (7'b0000101). Then 18 ×4 → falling=1, delta=−7 (7'b1111001). Then 63 ×4 → delta=+45. Then 0 ×4 → delta=−63 (7'b1000001).
- Run break: 30,30,31,30,30,30,30 → no pulse at the 31. The run restarts at 31, then restarts again at the following 30; the pulse follows the 4th 30 after the 31. Interleaving sample_valid=0 cycles into a run does not delay or break it beyond the valid count.
- TOL=1: 40,41,39,40 → pulse, stable_value=40. Then 40,42,42,42,42 → the 42 breaks the run (diff 2) and the pulse follows the 4th 42 with delta=+2.
- Samples presented during busy (e.g. 50 ×4 at edges N+1..N+4) → ignored, no pulse. HOLDOFF=0: 9 ×8 → pulses after the 4th and 8th samples.
- Reset after 3 matching samples, then 1 more matching sample → no pulse, all outputs 0. Reset during hold-off → busy clears next edge, and the next event reports first=1.

Source files
------------

// File: rtl/stress_trend_detector_if.sv
// rtl/stress_trend_detector_if.sv - sample input and stable-event outputs of the stress trend detector
//
// Purpose: bundles the sample stream and the held event outputs.
// Ports (signals):
//   sample_valid, sample      : sample presented this cycle and its value
//   stable_pulse              : one-cycle pulse per stable event
//   stable_value              : run reference of the last event (held)
//   first, rising, falling    : classification of the last event (held)
//   delta                     : signed (value - baseline) of the last event (held)
//   busy                      : hold-off in progress
// Modports: master drives samples, slave (the detector) drives results.
interface stress_trend_detector_if #(
  parameter int WIDTH = 6
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic             stable_pulse;
  logic [WIDTH-1:0] stable_value;
  logic             first;
  logic             rising;
  logic             falling;
  logic [WIDTH:0]   delta;
  logic             busy;

  modport master (
    output sample_valid, sample,
    input  stable_pulse, stable_value, first, rising, falling, delta, busy
  );

  modport slave (
    input  sample_valid, sample,
    output stable_pulse, stable_value, first, rising, falling, delta, busy
  );
endinterface

// File: rtl/stress_trend_detector.sv
// rtl/stress_trend_detector.sv - detects stable sample runs and reports their trend against the previous stable value
//
// Purpose: a reading is stable once DEPTH consecutive valid samples stay
// within TOL of the first sample of the run. Each stable reading is
// compared with the previous one (rise/fall/no change); a hold-off of
// HOLDOFF cycles follows every event, during which samples are ignored.
// Ports:
//   slow  : clock, all state changes on its rising edge
//   reset : synchronous, active-high
//   bus   : slave side of stress_trend_detector_if (samples in, results out)
module stress_trend_detector #(
  parameter int WIDTH   = 6,
  parameter int DEPTH   = 4,
  parameter int TOL     = 0,
  parameter int HOLDOFF = 4
) (
  input  logic                   slow,
  input  logic                   reset,
  stress_trend_detector_if.slave bus
);

  localparam logic [WIDTH-1:0] TOL_W   = TOL[WIDTH-1:0];
  localparam logic [3:0]       DEPTH_W = DEPTH[3:0];
  localparam logic [7:0]       HOLD_W  = HOLDOFF[7:0];

  typedef enum logic {
    S_FILL,
    S_HOLDOFF
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] run_ref;
  logic [3:0]       run_len;
  logic [WIDTH-1:0] baseline;
  logic             baseline_valid;
  logic [7:0]       hold_cnt;

  logic             pulse_r;
  logic [WIDTH-1:0] value_r;
  logic             first_r;
  logic             rising_r;
  logic             falling_r;
  logic [WIDTH:0]   delta_r;

  logic             accept;
  logic [WIDTH-1:0] diff;
  logic             mismatch;
  logic [3:0]       len_next;
  logic             fire;
  logic [WIDTH:0]   delta_calc;

  // Distance is a plain unsigned absolute difference: no modular wrap.
  always_comb begin
    accept     = (state == S_FILL) && bus.sample_valid;
    diff       = (bus.sample >= run_ref) ? (bus.sample - run_ref) : (run_ref - bus.sample);
    mismatch   = (run_len == 4'd0) || (diff > TOL_W);
    len_next   = mismatch ? 4'd1 : (run_len + 4'd1);
    // A restarted run has length 1 and DEPTH >= 2, so a firing run never
    // has a freshly loaded reference: run_ref is the event value.
    fire       = accept && (len_next == DEPTH_W);
    delta_calc = {1'b0, run_ref} - {1'b0, baseline};
  end

  always_ff @(posedge slow) begin
    if (reset) begin
      state <= S_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FILL: begin
        if (fire && (HOLD_W != 8'd0)) begin
          state_next = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (hold_cnt == 8'd0) begin
          state_next = S_FILL;
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  always_ff @(posedge slow) begin
    if (reset) begin
      run_ref        <= '0;
      run_len        <= '0;
      baseline       <= '0;
      baseline_valid <= 1'b0;
      hold_cnt       <= '0;
      pulse_r        <= 1'b0;
      value_r        <= '0;
      first_r        <= 1'b0;
      rising_r       <= 1'b0;
      falling_r      <= 1'b0;
      delta_r        <= '0;
    end else begin
      pulse_r <= 1'b0;
      if (state == S_HOLDOFF) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
      if (accept) begin
        if (fire) begin
          pulse_r <= 1'b1;
          value_r <= run_ref;
          if (!baseline_valid) begin
            first_r   <= 1'b1;
            rising_r  <= 1'b0;
            falling_r <= 1'b0;
            delta_r   <= '0;
          end else begin
            first_r   <= 1'b0;
            rising_r  <= (run_ref > baseline);
            falling_r <= (run_ref < baseline);
            delta_r   <= delta_calc;
          end
          baseline       <= run_ref;
          baseline_valid <= 1'b1;
          run_len        <= '0;
          // Unused when HOLDOFF is 0: the FSM never enters S_HOLDOFF.
          hold_cnt       <= HOLD_W - 8'd1;
        end else begin
          run_len <= len_next;
          if (mismatch) begin
            run_ref <= bus.sample;
          end
        end
      end
    end
  end

  assign bus.stable_pulse = pulse_r;
  assign bus.stable_value = value_r;
  assign bus.first        = first_r;
  assign bus.rising       = rising_r;
  assign bus.falling      = falling_r;
  assign bus.delta        = delta_r;
  assign bus.busy         = (state == S_HOLDOFF);

endmodule
